// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int BYTES_PER_WORD       = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 87;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the program loader.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, bit-timer and RX FSM.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rs
// START     | half a bit in; confirm start bit is still low (else glitch)
// DATA      | sampling 8 data bits LSB-first at bit centres
// STOP      | sampling stop bit; high = byte valid, low = framing error
// WAIT_HIGH | after a framing error, wait for the line to return high
module uart_rx_byte
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_TC = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_TC = TW'(CLKS_PER_BIT / 2 - 1);

  logic      rx_meta;
  logic      rs;
  rx_state_t state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Two-flop synchronizer; idle-high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rs      <= rx_meta;
    end
  end

  // RX FSM; the bit-timer is loaded with its terminal count and counts down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rs) begin
            state <= START;
            timer <= HALF_TC;
          end
        end
        START: begin
          if (timer == '0) begin
            if (!rs) begin
              state   <= DATA;
              timer   <= FULL_TC;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DATA: begin
          if (timer == '0) begin
            shreg   <= {rs, shreg[7:1]};
            timer   <= FULL_TC;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        STOP: begin
          if (timer == '0) begin
            if (rs) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Packs received UART bytes little-endian into words, writes them to
// instruction memory and holds the core in reset until the image is loaded.
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PROG_WORDS   = 1024,
  parameter int ADDR_W       = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxd,
  uart_prog_loader_if.master  mem,
  output logic                done,
  output logic                core_rst,
  output logic                frame_err
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PROG_WORDS);
  localparam logic [1:0]    LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic [1:0]    byte_idx;
  logic [23:0]   low_bytes;
  logic [CW-1:0] word_cnt;
  logic          loading;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // Gate on the word count rather than done so a byte landing between the
  // last strobe and done rising cannot start a new word.
  assign loading = (word_cnt != LAST_CNT);

  // Word packing and memory write strobe; wr_data only changes on a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx    <= '0;
      low_bytes   <= '0;
      word_cnt    <= '0;
      mem.wr_en   <= 1'b0;
      mem.wr_addr <= '0;
      mem.wr_data <= '0;
      done        <= 1'b0;
    end else begin
      mem.wr_en <= 1'b0;
      if (byte_valid && loading) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: low_bytes[7:0]   <= byte_data;
          2'd1: low_bytes[15:8]  <= byte_data;
          2'd2: low_bytes[23:16] <= byte_data;
          default: ;
        endcase
        if (byte_idx == LAST_LANE) begin
          mem.wr_en   <= 1'b1;
          mem.wr_data <= {byte_data, low_bytes};
          mem.wr_addr <= word_cnt[ADDR_W-1:0];
          word_cnt    <= word_cnt + CW'(1);
        end
      end
      if (!loading) done <= 1'b1;
    end
  end

  // Core reset follows done by one cycle and is forced high during reset.
  always_ff @(posedge clk) begin
    core_rst <= reset | ~done;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Upstream stage of the RISC-V core in the user project. Receives a program image over the UART rxd pad as 8N1 serial bytes and packs them little-endian into 32-bit words. Emits one instruction-memory write per word and holds the core in reset until PROG_WORDS words have loaded. Clocked by the muxed core clock, same domain as the core.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200); legal range >= 4.
- PROG_WORDS, 1024, number of 32-bit words in the image; legal range >= 1.
- ADDR_W, 10, word-address width; must satisfy 2**ADDR_W >= PROG_WORDS.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial input, idle high.
- wr_en  output  1  one-cycle write strobe to instruction/data memory.
- wr_addr  output  ADDR_W  word address of the current write.
- wr_data  output  32  word being written; byte 0 received goes to [7:0].
- done  output  1  sticky; all PROG_WORDS words written.
- core_rst  output  1  registered reset for the core: high while reset or !done.
- frame_err  output  1  sticky; a stop bit was sampled low.

Behaviour:
Decided interface: reset is synchronous and active-high; clock is clk.

Reset values:
- wr_en=0, wr_addr=0, wr_data=0, done=0, frame_err=0, core_rst=1.
- Synchronizer flops=1, FSM=IDLE, all counters=0.

Input synchronization:
- rxd passes through a 2-flop synchronizer; all FSM decisions use the synchronized bit rs.

RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rs==0, go to START and clear the bit-timer.
- START: at timer==CLKS_PER_BIT/2-1 (integer divide), sample rs.
  - rs==0: go to DATA, timer=0, bit_idx=0.
  - rs==1: treat as a glitch and return to IDLE; no error is flagged.
- DATA: at timer==CLKS_PER_BIT-1, shift rs into the shift register LSB-first, then reset the timer. After bit_idx 7 is sampled, go to STOP.
- STOP: at timer==CLKS_PER_BIT-1, sample rs.
  - rs==1: the byte is valid; go to IDLE.
  - rs==0: set frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rs==1, then go to IDLE. This prevents a break condition from being read as back-to-back start bits.

Byte assembly:
- Each valid byte is placed in wr_data lane byte_idx (0..3); byte_idx then increments modulo 4.
- On the 4th byte, wr_en=1 in the cycle after the stop-bit sample, with the full word on wr_data and word_cnt on wr_addr.
- word_cnt increments in the same cycle wr_en is high. wr_en is high for exactly one cycle.
- wr_addr and wr_data hold their values after the strobe until the next write.
- When word_cnt reaches PROG_WORDS, done=1 on the cycle after the last wr_en.
- After done, the RX FSM keeps running but produces no writes and no further byte_idx changes. frame_err can still set.

core_rst:
- Registered as reset | !done.
- Falls one cycle after done rises. Once low, stays low until the next reset.

Other rules:
- A framing error does not advance byte_idx; the partial word is kept.
- A reset mid-frame or mid-word abandons everything. Loading restarts at address 0, byte lane 0.

Decomposition:
- Shared package `uart_prog_pkg` holds:
  - the rx_state_t enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - constant BYTES_PER_WORD=4;
  - the default CLKS_PER_BIT.
- Sub-module `uart_rx_byte` is natural: synchronizer, FSM and bit-timer, with outputs byte_valid, byte_data[7:0] and frame_err.
- The top level does word packing, addressing, done and core_rst.

Test Plan:
- Reset, then idle line (CLKS_PER_BIT=8, PROG_WORDS=2) -> core_rst=1, done=0, wr_en never asserts for 1000 cycles.
- Send bytes 0x13,0x00,0x00,0x00 -> exactly one wr_en pulse with wr_addr=0, wr_data=0x00000013; done stays 0.
- Send a second word 0xEF,0xBE,0xAD,0xDE -> wr_addr=1, wr_data=0xDEADBEEF; done=1 next cycle; core_rst=0 one cycle later; a further byte 0x55 causes no wr_en.
- Low pulse of 2 cycles on rxd (less than half a bit) -> no byte captured, frame_err=0, FSM back in IDLE.
- Byte with stop bit forced low, then line held low 30 cycles, then a clean 0xA5 -> frame_err=1, errored byte discarded, 0xA5 lands in byte lane 0.
- Assert reset after 2 bytes of a word, then send 4 bytes 0x01..0x04 -> wr_addr=0, wr_data=0x04030201, frame_err=0.
